// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared FSM states, RGB565 bar colours and default timing for the OV7670 emulator.
package ov7670_pkg;
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT} state_t;
  localparam logic [15:0] BAR_COLORS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };
  localparam int DEF_H_PIXELS = 160;
  localparam int DEF_V_LINES = 120;
  localparam int DEF_VSYNC_LEN = 3;
  localparam int DEF_V_BACK = 17;
  localparam int DEF_H_BLANK = 144;
  localparam int DEF_V_FRONT = 10;
  function automatic int max2(int a, int b);
    return a > b ? a : b;
  endfunction
  function automatic int frame_period(int h, int v, int vs, int vb, int hb, int vf);
    return vs + vb + v * (2 * h + hb) + vf;
  endfunction
endpackage

// File: rtl/ov7670_pattern_gen.sv
// ov7670_pattern_gen: RGB565 byte source; colour bars by default, x/y gradient when EMU_GRADIENT_EN is defined.
`ifdef EMU_GRADIENT_EN
module ov7670_pattern_gen #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic          phase,
  output logic [7:0]    data
);
  logic [15:0] pixel;
  always_comb begin
    pixel = {5'(x), 6'(y), 5'(x) ^ 5'(y)};
    data = phase ? pixel[7:0] : pixel[15:8];
  end
endmodule
`else
module ov7670_pattern_gen
  import ov7670_pkg::*;
(
  input  logic [2:0] bar,
  input  logic       phase,
  output logic [7:0] data
);
  logic [15:0] pixel;
  always_comb begin
    pixel = BAR_COLORS[bar];
    data = phase ? pixel[7:0] : pixel[15:8];
  end
endmodule
`endif

// File: rtl/ov7670_emulator.sv
// ov7670_emulator: OV7670 RGB565 Vsync/Href/Data stream source.
// Define EMU_GRADIENT_EN to replace the colour bars with an x/y gradient; timing is unchanged.
module ov7670_emulator
  import ov7670_pkg::*;
#(
  parameter int H_PIXELS  = DEF_H_PIXELS,
  parameter int V_LINES   = DEF_V_LINES,
  parameter int VSYNC_LEN = DEF_VSYNC_LEN,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int H_BLANK   = DEF_H_BLANK,
  parameter int V_FRONT   = DEF_V_FRONT
) (
  input  logic       Pclk,
  input  logic       Rst_n,
  input  logic       Run,
  output logic       Vsync,
  output logic       Href,
  output logic [7:0] Data,
  output logic [7:0] Frame_cnt,
  output logic       Busy
);
  localparam int BAR_W = H_PIXELS / 8;
  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = V_LINES > 1 ? $clog2(V_LINES) : 1;
  localparam int BW = BAR_W > 1 ? $clog2(BAR_W) : 1;
  localparam int CMAX = max2(max2(VSYNC_LEN, V_BACK), max2(H_BLANK, V_FRONT));
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [2:0] bar, bar_n;
  logic phase, phase_n, line_end, emit, first, bar_last;
  logic [7:0] pix;
  // x/phase/bar describe the byte on Data; the _n values describe the byte about to be registered
  always_comb begin
    line_end = state == LINE && x == XW'(H_PIXELS - 1) && phase;
    emit = (state == VBACK && cnt == CW'(V_BACK - 1)) ||
           (state == HBLANK && cnt == CW'(H_BLANK - 1) && y != YW'(V_LINES - 1)) ||
           (state == LINE && !line_end);
    first = emit && state != LINE;
    bar_last = bcnt == BW'(BAR_W - 1);
    x_n = first ? '0 : x + XW'(phase);
    phase_n = !first && !phase;
    bcnt_n = first || (phase && bar_last) ? '0 : bcnt + BW'(phase);
    bar_n = first ? '0 : bar + 3'(phase && bar_last);
    y_n = first ? (state == VBACK ? '0 : y + 1'b1) : y;
  end
`ifdef EMU_GRADIENT_EN
  ov7670_pattern_gen #(.XW(XW), .YW(YW)) u_pat (.x(x_n), .y(y_n), .phase(phase_n), .data(pix));
`else
  ov7670_pattern_gen u_pat (.bar(bar_n), .phase(phase_n), .data(pix));
`endif
  always_ff @(posedge Pclk) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt <= '0;
      x <= '0;
      y <= '0;
      phase <= 1'b0;
      bar <= '0;
      bcnt <= '0;
      Vsync <= 1'b0;
      Href <= 1'b0;
      Data <= 8'h00;
      Frame_cnt <= 8'h00;
      Busy <= 1'b0;
    end else begin
      Href <= emit;
      Data <= emit ? pix : 8'h00;
      if (emit) begin
        x <= x_n;
        y <= y_n;
        phase <= phase_n;
        bar <= bar_n;
        bcnt <= bcnt_n;
      end
      case (state)
        IDLE: if (Run) begin
          state <= VSYNC;
          Vsync <= 1'b1;
          Busy <= 1'b1;
        end
        VSYNC: if (cnt == CW'(VSYNC_LEN - 1)) begin
          state <= VBACK;
          Vsync <= 1'b0;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        VBACK: if (cnt == CW'(V_BACK - 1)) begin
          state <= LINE;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        LINE: if (line_end) state <= HBLANK;
        HBLANK: if (cnt == CW'(H_BLANK - 1)) begin
          state <= y == YW'(V_LINES - 1) ? VFRONT : LINE;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        VFRONT: if (cnt == CW'(V_FRONT - 1)) begin
          state <= Run ? VSYNC : IDLE;
          Vsync <= Run;
          Busy <= Run;
          Frame_cnt <= Frame_cnt + 1'b1;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ov7670_emulator.sv
// tb_ov7670_emulator: frame-timing model checked every cycle, plus directed literal checks and frame-buffer capture.
module tb_ov7670_emulator;
  localparam int H = 16, V = 4, VS = 3, VB = 2, HB = 4, VF = 2;
  localparam int LP = 2 * H + HB;
  localparam int P = VS + VB + V * LP + VF;
  localparam logic [15:0] BARS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };
  logic Pclk = 1'b0, Rst_n = 1'b0, Run = 1'b0;
  logic Vsync, Href, Busy;
  logic [7:0] Data, Frame_cnt;
  int errors = 0, checks = 0;
  int t = 0, fc = 0;
  bit cmp_en = 1'b0;
  logic ev, eh;
  logic [7:0] ed;
  logic [15:0] ep;
  int u, k;

  ov7670_emulator #(
    .H_PIXELS(H), .V_LINES(V), .VSYNC_LEN(VS), .V_BACK(VB), .H_BLANK(HB), .V_FRONT(VF)
  ) dut (
    .Pclk(Pclk), .Rst_n(Rst_n), .Run(Run), .Vsync(Vsync), .Href(Href),
    .Data(Data), .Frame_cnt(Frame_cnt), .Busy(Busy)
  );

  always #5 Pclk = ~Pclk;

  function automatic logic [15:0] pix(int px, int ln);
`ifdef EMU_GRADIENT_EN
    return {5'(px), 6'(ln), 5'(px ^ ln)};
`else
    return BARS[px / (H / 8)];
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Pclk);
  endtask

  // t = position inside the current frame (1 = first Vsync cycle), 0 when idle
  always @(posedge Pclk) begin
    if (!Rst_n) begin
      t <= 0;
      fc <= 0;
    end else if (t == 0) t <= Run ? 1 : 0;
    else if (t == P) begin
      fc <= (fc + 1) % 256;
      t <= Run ? 1 : 0;
    end else t <= t + 1;
  end

  always @(negedge Pclk) begin
    if (cmp_en) begin
      u = t - (VS + VB + 1);
      k = u >= 0 ? u % LP : 0;
      ev = t >= 1 && t <= VS;
      eh = t != 0 && u >= 0 && u < V * LP && k < 2 * H;
      ed = 8'h00;
      if (eh) begin
        ep = pix(k / 2, u / LP);
        ed = (k % 2 == 1) ? ep[7:0] : ep[15:8];
      end
      checks++;
      if ({Vsync, Href, Data, Busy, Frame_cnt} !== {ev, eh, ed, t != 0, fc[7:0]}) begin
        errors++;
        $display("FAIL cycle_outputs t=%0d: got vs=%b href=%b data=%h busy=%b fc=%0d expected vs=%b href=%b data=%h busy=%b fc=%0d",
                 t, Vsync, Href, Data, Busy, Frame_cnt, ev, eh, ed, t != 0, fc[7:0]);
      end
    end
  end

  initial begin
    logic [7:0] line0 [32];
    logic [7:0] exp0 [32];
    logic [7:0] p5 [2];
    logic [15:0] fb [V][H];
    logic [7:0] hi, prev_fc;
    int pulses, first_href, vs_cnt, bad_low, nv, row, col;
    bit prev_href, hb, wrap;
`ifdef EMU_GRADIENT_EN
    for (int i = 0; i < 16; i++) begin
      exp0[2*i] = 8'(i << 3);
      exp0[2*i+1] = 8'(i);
    end
`else
    exp0 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'hFF, 8'hE0,
             8'h07, 8'hFF, 8'h07, 8'hFF, 8'h07, 8'hE0, 8'h07, 8'hE0,
             8'hF8, 8'h1F, 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'hF8, 8'h00,
             8'h00, 8'h1F, 8'h00, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    step(3);
    cmp_en = 1'b1;
    chk("reset_outputs", 32'({Vsync, Href, Data, Busy, Frame_cnt}), 32'h0);
    // start a frame, then reset it during line 1
    Rst_n = 1'b1;
    Run = 1'b1;
    step(1);
    chk("start_vsync", 32'(Vsync), 32'h1);
    step(49);
    chk("line1_href", 32'(Href), 32'h1);
    Rst_n = 1'b0;
    step(1);
    chk("midreset_outputs", 32'({Vsync, Href, Data, Busy}), 32'h0);
    chk("midreset_frame_cnt", 32'(Frame_cnt), 32'h0);
    Rst_n = 1'b1;
    step(1);
    chk("restart_vsync", 32'(Vsync), 32'h1);
    // one full frame from its first Vsync cycle
    pulses = 0; first_href = 0; vs_cnt = 0; bad_low = 0; prev_href = 1'b0;
    for (int r = 1; r <= 152; r++) begin
      if (Href && !prev_href) pulses++;
      if (Href && first_href == 0) first_href = r;
      if (Vsync && r <= 151) vs_cnt++;
      if (!Href && Data != 8'h00) bad_low++;
      if (r >= 6 && r <= 37) line0[r-6] = Data;
      if (r == 88) p5[0] = Data;
      if (r == 89) p5[1] = Data;
      if (r == 151) chk("frame_cnt_before_end", 32'(Frame_cnt), 32'h0);
      if (r == 152) begin
        chk("frame_cnt_after_end", 32'(Frame_cnt), 32'h1);
        chk("vsync_next_frame", 32'(Vsync), 32'h1);
      end
      prev_href = Href;
      if (r < 152) step(1);
    end
    chk("vsync_len", 32'(vs_cnt), 32'd3);
    chk("first_href_cycle", 32'(first_href), 32'd6);
    chk("href_pulses", 32'(pulses), 32'd4);
    chk("data_zero_when_href_low", 32'(bad_low), 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("line0_byte%0d", i), 32'(line0[i]), 32'(exp0[i]));
`ifdef EMU_GRADIENT_EN
    chk("line2_px5_hi", 32'(p5[0]), 32'h28);
    chk("line2_px5_lo", 32'(p5[1]), 32'h47);
`else
    chk("line2_px5_hi", 32'(p5[0]), 32'h07);
    chk("line2_px5_lo", 32'(p5[1]), 32'hFF);
`endif
    // drop Run during line 2 of the second frame
    step(80);
    Run = 1'b0;
    step(70);
    chk("stop_busy_last_cycle", 32'(Busy), 32'h1);
    step(1);
    chk("stop_busy", 32'(Busy), 32'h0);
    chk("stop_frame_cnt", 32'(Frame_cnt), 32'd2);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (Vsync) nv++;
    end
    chk("no_vsync_after_stop", 32'(nv), 32'd0);
    // 256 back-to-back frames with frame-buffer capture
    for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) fb[r][c] = 'x;
    row = -1; col = 0; hb = 1'b0; hi = 8'h00; prev_href = 1'b0; wrap = 1'b0;
    prev_fc = Frame_cnt;
    Run = 1'b1;
    for (int i = 1; i <= 256 * P; i++) begin
      step(1);
      if (Vsync) row = -1;
      if (Href && !prev_href) begin
        row++;
        col = 0;
        hb = 1'b0;
      end
      if (Href) begin
        if (!hb) hi = Data;
        else if (row >= 0 && row < V && col < H) begin
          fb[row][col] = {hi, Data};
          col++;
        end
        hb = !hb;
      end
      prev_href = Href;
      if (prev_fc == 8'd255 && Frame_cnt == 8'd0) wrap = 1'b1;
      prev_fc = Frame_cnt;
      if (i == 255 * P + 50) Run = 1'b0;
    end
    step(1);
    chk("wrap_seen", 32'(wrap), 32'h1);
    chk("after_256_frame_cnt", 32'(Frame_cnt), 32'd2);
    chk("after_256_busy", 32'(Busy), 32'h0);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        chk($sformatf("fb_r%0d_c%0d", r, c), 32'(fb[r][c]), 32'(pix(c, r)));
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
